// File: rtl/csi2_b2p_line_sequencer.sv
// CSI-2 byte-clock line sequencer: frame/line tracking, word-count truncation, inter-line gap.
// Optional build macro LINE_COUNT_CHECK_EN enables the lines-per-frame check at FE.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | outside a frame, waiting for FS
// S_FRAME | inside a frame, ready to accept an active-video line header
// S_LINE  | forwarding payload beats of the accepted line
// S_GAP   | enforced idle time after a line before the next header
module csi2_b2p_line_sequencer #(
    parameter int unsigned NUM_RX_LANE = 4,
    parameter int unsigned RX_GEAR     = 8,
    parameter logic [5:0]  DT_AV       = 6'h2B,
    parameter int unsigned LINE_GAP    = 16,
    parameter int unsigned V_ACTIVE    = 1080
) (
    input  logic                            clk_byte_i,
    input  logic                            reset_byte_i,
    input  logic                            sp_en_i,
    input  logic                            lp_en_i,
    input  logic [5:0]                      dt_i,
    input  logic [15:0]                     wc_i,
    input  logic                            payload_en_i,
    input  logic [NUM_RX_LANE*RX_GEAR-1:0]  payload_i,
    output logic                            sp_en_o,
    output logic [5:0]                      dt_o,
    output logic                            lp_av_en_o,
    output logic [15:0]                     wc_o,
    output logic                            payload_en_o,
    output logic [NUM_RX_LANE*RX_GEAR-1:0]  payload_o,
    output logic                            frame_active_o,
    output logic [15:0]                     line_cnt_o,
    output logic                            err_seq_o,
    output logic                            err_wc_o,
    output logic                            err_ovf_o,
    output logic                            err_lines_o
);

    localparam int unsigned PW       = NUM_RX_LANE * RX_GEAR;
    localparam logic [15:0] BPC      = 16'(PW / 8);
    localparam logic [7:0]  GAP_LOAD = 8'(LINE_GAP);
    localparam logic [5:0]  DT_FS    = 6'h00;
    localparam logic [5:0]  DT_FE    = 6'h01;

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_LINE, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     remaining_q, remaining_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic            started_q, started_d;
    logic            drain_q, drain_d;
    logic [15:0]     line_cnt_q, line_cnt_d;
    logic            frame_active_q, frame_active_d;
    logic            sp_en_q, sp_en_d;
    logic [5:0]      dt_q, dt_d;
    logic            lp_av_en_q, lp_av_en_d;
    logic [15:0]     wc_q, wc_d;
    logic            payload_en_q, payload_en_d;
    logic [PW-1:0]   payload_q, payload_d;
    logic            err_seq_q, err_seq_d;
    logic            err_wc_q, err_wc_d;
    logic            err_ovf_q, err_ovf_d;
`ifdef LINE_COUNT_CHECK_EN
    localparam logic [15:0] V_ACTIVE_W = 16'(V_ACTIVE);
    logic            err_lines_q, err_lines_d;
`endif

    logic is_fs, is_fe;
    assign is_fs = sp_en_i && (dt_i == DT_FS);
    assign is_fe = sp_en_i && (dt_i == DT_FE);

    always_ff @(posedge clk_byte_i or posedge reset_byte_i) begin
        if (reset_byte_i) begin
            state_q        <= S_IDLE;
            remaining_q    <= '0;
            gap_cnt_q      <= '0;
            started_q      <= 1'b0;
            drain_q        <= 1'b0;
            line_cnt_q     <= '0;
            frame_active_q <= 1'b0;
            sp_en_q        <= 1'b0;
            dt_q           <= '0;
            lp_av_en_q     <= 1'b0;
            wc_q           <= '0;
            payload_en_q   <= 1'b0;
            payload_q      <= '0;
            err_seq_q      <= 1'b0;
            err_wc_q       <= 1'b0;
            err_ovf_q      <= 1'b0;
`ifdef LINE_COUNT_CHECK_EN
            err_lines_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            gap_cnt_q      <= gap_cnt_d;
            started_q      <= started_d;
            drain_q        <= drain_d;
            line_cnt_q     <= line_cnt_d;
            frame_active_q <= frame_active_d;
            sp_en_q        <= sp_en_d;
            dt_q           <= dt_d;
            lp_av_en_q     <= lp_av_en_d;
            wc_q           <= wc_d;
            payload_en_q   <= payload_en_d;
            payload_q      <= payload_d;
            err_seq_q      <= err_seq_d;
            err_wc_q       <= err_wc_d;
            err_ovf_q      <= err_ovf_d;
`ifdef LINE_COUNT_CHECK_EN
            err_lines_q    <= err_lines_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        gap_cnt_d      = gap_cnt_q;
        started_d      = started_q;
        drain_d        = drain_q;
        line_cnt_d     = line_cnt_q;
        frame_active_d = frame_active_q;
        sp_en_d        = 1'b0;
        dt_d           = dt_q;
        lp_av_en_d     = 1'b0;
        wc_d           = wc_q;
        payload_en_d   = 1'b0;
        payload_d      = payload_q;
        err_seq_d      = 1'b0;
        err_wc_d       = 1'b0;
        err_ovf_d      = 1'b0;
`ifdef LINE_COUNT_CHECK_EN
        err_lines_d    = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (is_fs) begin
                    sp_en_d        = 1'b1;
                    dt_d           = dt_i;
                    line_cnt_d     = '0;
                    frame_active_d = 1'b1;
                    state_d        = S_FRAME;
                end else if (is_fe) begin
                    err_seq_d = 1'b1;
                end
                if (lp_en_i) begin
                    err_seq_d = 1'b1;
                end
            end

            S_FRAME, S_GAP: begin
                // Countdown first so an FE or FS below can still override state_d.
                if (state_q == S_GAP) begin
                    drain_d = 1'b0;
                    if (drain_q && payload_en_i) begin
                        err_wc_d = 1'b1;
                    end
                    if (gap_cnt_q <= 8'd1) begin
                        state_d = S_FRAME;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                    end
                end

                if (is_fe) begin
                    sp_en_d        = 1'b1;
                    dt_d           = dt_i;
                    frame_active_d = 1'b0;
                    state_d        = S_IDLE;
`ifdef LINE_COUNT_CHECK_EN
                    err_lines_d    = (line_cnt_q != V_ACTIVE_W);
`endif
                end else if (is_fs) begin
                    err_seq_d  = 1'b1;
                    sp_en_d    = 1'b1;
                    dt_d       = dt_i;
                    line_cnt_d = '0;
                end

                if (sp_en_i && lp_en_i) begin
                    err_seq_d = 1'b1;
                end else if (lp_en_i) begin
                    if (state_q == S_GAP) begin
                        err_ovf_d = 1'b1;
                    end else if (dt_i == DT_AV) begin
                        if (wc_i == 16'd0) begin
                            err_wc_d = 1'b1;
                        end else begin
                            lp_av_en_d  = 1'b1;
                            dt_d        = dt_i;
                            wc_d        = wc_i;
                            remaining_d = wc_i;
                            started_d   = 1'b0;
                            state_d     = S_LINE;
                        end
                    end
                end
            end

            S_LINE: begin
                if (is_fe) begin
                    // Aborted line still counts towards the frame's line total.
                    err_wc_d       = 1'b1;
                    sp_en_d        = 1'b1;
                    dt_d           = dt_i;
                    line_cnt_d     = line_cnt_q + 16'd1;
                    frame_active_d = 1'b0;
                    state_d        = S_IDLE;
`ifdef LINE_COUNT_CHECK_EN
                    err_lines_d    = ((line_cnt_q + 16'd1) != V_ACTIVE_W);
`endif
                end else begin
                    if (sp_en_i || lp_en_i) begin
                        err_seq_d = 1'b1;
                    end
                    if (payload_en_i) begin
                        payload_en_d = 1'b1;
                        payload_d    = payload_i;
                        started_d    = 1'b1;
                        if (remaining_q <= BPC) begin
                            remaining_d = '0;
                            line_cnt_d  = line_cnt_q + 16'd1;
                            gap_cnt_d   = GAP_LOAD;
                            drain_d     = 1'b1;
                            state_d     = S_GAP;
                        end else begin
                            remaining_d = remaining_q - BPC;
                        end
                    end else if (started_q) begin
                        err_wc_d   = 1'b1;
                        line_cnt_d = line_cnt_q + 16'd1;
                        gap_cnt_d  = GAP_LOAD;
                        drain_d    = 1'b0;
                        state_d    = S_GAP;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign sp_en_o        = sp_en_q;
    assign dt_o           = dt_q;
    assign lp_av_en_o     = lp_av_en_q;
    assign wc_o           = wc_q;
    assign payload_en_o   = payload_en_q;
    assign payload_o      = payload_q;
    assign frame_active_o = frame_active_q;
    assign line_cnt_o     = line_cnt_q;
    assign err_seq_o      = err_seq_q;
    assign err_wc_o       = err_wc_q;
    assign err_ovf_o      = err_ovf_q;
`ifdef LINE_COUNT_CHECK_EN
    assign err_lines_o    = err_lines_q;
`else
    assign err_lines_o    = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_b2p_line_sequencer.sv
// Directed bench for csi2_b2p_line_sequencer (4 lanes, gear 8, LINE_GAP 16, V_ACTIVE 4).
module tb_csi2_b2p_line_sequencer;

    localparam int NL  = 4;
    localparam int GR  = 8;
    localparam int PW  = NL * GR;
    localparam int GAP = 16;
    localparam int VA  = 4;
`ifdef LINE_COUNT_CHECK_EN
    localparam logic EXP_LINES_ERR = 1'b1;
`else
    localparam logic EXP_LINES_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sp_en_i, lp_en_i, payload_en_i;
    logic [5:0]    dt_i;
    logic [15:0]   wc_i;
    logic [PW-1:0] payload_i;
    logic          sp_en_o, lp_av_en_o, payload_en_o, frame_active_o;
    logic [5:0]    dt_o;
    logic [15:0]   wc_o, line_cnt_o;
    logic [PW-1:0] payload_o;
    logic          err_seq_o, err_wc_o, err_ovf_o, err_lines_o;

    always #5 clk = ~clk;

    csi2_b2p_line_sequencer #(
        .NUM_RX_LANE(NL), .RX_GEAR(GR), .DT_AV(6'h2B), .LINE_GAP(GAP), .V_ACTIVE(VA)
    ) dut (
        .clk_byte_i(clk), .reset_byte_i(rst),
        .sp_en_i(sp_en_i), .lp_en_i(lp_en_i), .dt_i(dt_i), .wc_i(wc_i),
        .payload_en_i(payload_en_i), .payload_i(payload_i),
        .sp_en_o(sp_en_o), .dt_o(dt_o), .lp_av_en_o(lp_av_en_o), .wc_o(wc_o),
        .payload_en_o(payload_en_o), .payload_o(payload_o),
        .frame_active_o(frame_active_o), .line_cnt_o(line_cnt_o),
        .err_seq_o(err_seq_o), .err_wc_o(err_wc_o), .err_ovf_o(err_ovf_o),
        .err_lines_o(err_lines_o)
    );

    int total = 0;
    int bad   = 0;

    // Running event counts, sampled mid-cycle; tests take differences.
    int n_pay = 0, n_seq = 0, n_wc = 0, n_ovf = 0, n_lpav = 0;
    always @(negedge clk) begin
        n_pay  += int'(payload_en_o);
        n_seq  += int'(err_seq_o);
        n_wc   += int'(err_wc_o);
        n_ovf  += int'(err_ovf_o);
        n_lpav += int'(lp_av_en_o);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_sp(input logic [5:0] dt);
        sp_en_i = 1'b1; dt_i = dt;
        step();
        sp_en_i = 1'b0; dt_i = 6'h00;
    endtask

    task automatic send_lp(input logic [5:0] dt, input logic [15:0] wc);
        lp_en_i = 1'b1; dt_i = dt; wc_i = wc;
        step();
        lp_en_i = 1'b0; dt_i = 6'h00; wc_i = 16'h0;
    endtask

    // Drives nbeats contiguous beats; the first nfwd must appear at 1-cycle latency.
    task automatic send_payload(input string name, input int nbeats, input int nfwd);
        for (int i = 0; i < nbeats; i++) begin
            payload_en_i = 1'b1;
            payload_i    = PW'(32'hA000_0000 + i);
            step();
            total++;
            if (i < nfwd) begin
                if (payload_en_o !== 1'b1 || payload_o !== PW'(32'hA000_0000 + i)) begin
                    bad++;
                    $display("FAIL %s beat %0d: got en=%b data=%h, want en=1 data=%h",
                             name, i, payload_en_o, payload_o, PW'(32'hA000_0000 + i));
                end
            end else if (payload_en_o !== 1'b0) begin
                bad++;
                $display("FAIL %s beat %0d: got en=%b, want en=0", name, i, payload_en_o);
            end
        end
        payload_en_i = 1'b0;
        payload_i    = '0;
    endtask

    task automatic check_cnt(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sp_en_i = 1'b0; lp_en_i = 1'b0; payload_en_i = 1'b0;
        dt_i = '0; wc_i = '0; payload_i = '0;
        idle(3);
        rst = 1'b0;
        idle(1);
        total++;
        if ({sp_en_o, lp_av_en_o, payload_en_o, frame_active_o, err_seq_o, err_wc_o,
             err_ovf_o, err_lines_o} !== 8'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b, want 00000000",
                     {sp_en_o, lp_av_en_o, payload_en_o, frame_active_o, err_seq_o,
                      err_wc_o, err_ovf_o, err_lines_o});
        end
        total++;
        if (line_cnt_o !== 16'd0 || wc_o !== 16'd0 || dt_o !== 6'd0 || payload_o !== '0) begin
            bad++;
            $display("FAIL reset_data: got line_cnt=%0d wc=%0d dt=%h payload=%h, want all 0",
                     line_cnt_o, wc_o, dt_o, payload_o);
        end
    endtask

    task automatic test_basic_line();
        int p0 = n_pay, s0 = n_seq, w0 = n_wc, o0 = n_ovf;
        send_sp(6'h00);
        total++;
        if (sp_en_o !== 1'b1 || dt_o !== 6'h00 || frame_active_o !== 1'b1 || line_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL basic_fs: got sp=%b dt=%h fa=%b lc=%0d, want 1 00 1 0",
                     sp_en_o, dt_o, frame_active_o, line_cnt_o);
        end
        send_lp(6'h2B, 16'd1600);
        total++;
        if (lp_av_en_o !== 1'b1 || wc_o !== 16'd1600 || dt_o !== 6'h2B) begin
            bad++;
            $display("FAIL basic_hdr: got lp_av=%b wc=%0d dt=%h, want 1 1600 2b",
                     lp_av_en_o, wc_o, dt_o);
        end
        send_payload("basic", 400, 400);
        check_cnt("basic_line_cnt", int'(line_cnt_o), 1);
        idle(20);
        send_sp(6'h01);
        total++;
        if (sp_en_o !== 1'b1 || dt_o !== 6'h01 || frame_active_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_fe: got sp=%b dt=%h fa=%b, want 1 01 0", sp_en_o, dt_o, frame_active_o);
        end
        idle(1);
        check_cnt("basic_beats", n_pay - p0, 400);
        check_cnt("basic_errors", (n_seq - s0) + (n_wc - w0) + (n_ovf - o0), 0);
    endtask

    task automatic test_wc_saturate();
        int p0 = n_pay, w0 = n_wc;
        send_sp(6'h00);
        send_lp(6'h2B, 16'd1602);
        send_payload("sat", 401, 401);
        idle(20);
        send_sp(6'h01);
        idle(1);
        check_cnt("sat_beats", n_pay - p0, 401);
        check_cnt("sat_line_cnt", int'(line_cnt_o), 1);
        check_cnt("sat_err_wc", n_wc - w0, 0);
    endtask

    task automatic test_truncate();
        int p0 = n_pay, w0 = n_wc;
        send_sp(6'h00);
        send_lp(6'h2B, 16'd16);
        send_payload("trunc", 6, 4);
        idle(20);
        check_cnt("trunc_beats", n_pay - p0, 4);
        check_cnt("trunc_err_wc", n_wc - w0, 1);
        check_cnt("trunc_line_cnt", int'(line_cnt_o), 1);
        send_sp(6'h01);
        idle(2);
    endtask

    task automatic test_gap_overflow();
        int o0 = n_ovf, a0 = n_lpav, w0 = n_wc;
        send_sp(6'h00);
        send_lp(6'h2B, 16'd8);
        send_payload("gap_l1", 2, 2);
        idle(4);
        send_lp(6'h2B, 16'd8);
        total++;
        if (err_ovf_o !== 1'b1 || lp_av_en_o !== 1'b0) begin
            bad++;
            $display("FAIL gap_ovf_pulse: got ovf=%b lp_av=%b, want 1 0", err_ovf_o, lp_av_en_o);
        end
        idle(12);
        send_lp(6'h2B, 16'd8);
        total++;
        if (lp_av_en_o !== 1'b1) begin
            bad++;
            $display("FAIL gap_after_accept: got lp_av=%b, want 1", lp_av_en_o);
        end
        send_payload("gap_l2", 2, 2);
        check_cnt("gap_line_cnt", int'(line_cnt_o), 2);
        // Payload ending early closes the line with a word-count error.
        idle(20);
        send_lp(6'h2B, 16'd16);
        send_payload("gap_short", 2, 2);
        idle(2);
        check_cnt("gap_short_line_cnt", int'(line_cnt_o), 3);
        send_sp(6'h01);
        total++;
        if (sp_en_o !== 1'b1 || frame_active_o !== 1'b0) begin
            bad++;
            $display("FAIL gap_fe: got sp=%b fa=%b, want 1 0", sp_en_o, frame_active_o);
        end
        idle(1);
        check_cnt("gap_ovf_count", n_ovf - o0, 1);
        check_cnt("gap_lpav_count", n_lpav - a0, 3);
        check_cnt("gap_short_err_wc", n_wc - w0, 1);
    endtask

    task automatic test_seq_errors();
        int s0 = n_seq, a0 = n_lpav;
        send_lp(6'h2B, 16'd16);
        total++;
        if (err_seq_o !== 1'b1 || lp_av_en_o !== 1'b0) begin
            bad++;
            $display("FAIL seq_lp_idle: got seq=%b lp_av=%b, want 1 0", err_seq_o, lp_av_en_o);
        end
        send_sp(6'h01);
        total++;
        if (err_seq_o !== 1'b1 || sp_en_o !== 1'b0) begin
            bad++;
            $display("FAIL seq_fe_idle: got seq=%b sp=%b, want 1 0", err_seq_o, sp_en_o);
        end
        sp_en_i = 1'b1; lp_en_i = 1'b1; dt_i = 6'h00; wc_i = 16'd16;
        step();
        sp_en_i = 1'b0; lp_en_i = 1'b0; wc_i = 16'd0;
        total++;
        if (err_seq_o !== 1'b1 || sp_en_o !== 1'b1 || lp_av_en_o !== 1'b0 || frame_active_o !== 1'b1) begin
            bad++;
            $display("FAIL seq_fs_lp: got seq=%b sp=%b lp_av=%b fa=%b, want 1 1 0 1",
                     err_seq_o, sp_en_o, lp_av_en_o, frame_active_o);
        end
        send_sp(6'h01);
        idle(1);
        check_cnt("seq_count", n_seq - s0, 3);
        check_cnt("seq_lpav_count", n_lpav - a0, 0);
    endtask

    task automatic test_fe_abort();
        int w0 = n_wc;
        send_sp(6'h00);
        send_lp(6'h2B, 16'd16);
        send_sp(6'h01);
        total++;
        if (err_wc_o !== 1'b1 || sp_en_o !== 1'b1 || frame_active_o !== 1'b0 || line_cnt_o !== 16'd1) begin
            bad++;
            $display("FAIL abort_fe: got wc_err=%b sp=%b fa=%b lc=%0d, want 1 1 0 1",
                     err_wc_o, sp_en_o, frame_active_o, line_cnt_o);
        end
        idle(1);
        check_cnt("abort_err_wc", n_wc - w0, 1);
    endtask

    task automatic run_frame(input int nlines, output logic lines_err);
        send_sp(6'h00);
        for (int l = 0; l < nlines; l++) begin
            send_lp(6'h2B, 16'd4);
            send_payload("lc_line", 1, 1);
            idle(17);
        end
        send_sp(6'h01);
        lines_err = err_lines_o;
        idle(1);
    endtask

    task automatic test_line_count();
        logic e;
        run_frame(3, e);
        total++;
        if (e !== EXP_LINES_ERR) begin
            bad++;
            $display("FAIL lines_3: got err_lines=%b, want %b", e, EXP_LINES_ERR);
        end
        run_frame(4, e);
        total++;
        if (e !== 1'b0) begin
            bad++;
            $display("FAIL lines_4: got err_lines=%b, want 0", e);
        end
    endtask

    task automatic test_reset_midline();
        int p0;
        send_sp(6'h00);
        send_lp(6'h2B, 16'd64);
        payload_en_i = 1'b1; payload_i = PW'(32'h1234_5678);
        step();
        #2 rst = 1'b1;
        #1;
        total++;
        if (payload_en_o !== 1'b0 || frame_active_o !== 1'b0 || line_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL rst_async: got en=%b fa=%b lc=%0d, want 0 0 0",
                     payload_en_o, frame_active_o, line_cnt_o);
        end
        idle(2);
        rst = 1'b0;
        p0 = n_pay;
        idle(8);
        payload_en_i = 1'b0;
        idle(1);
        check_cnt("rst_no_beats", n_pay - p0, 0);
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_wc_saturate();
        test_truncate();
        test_gap_overflow();
        test_seq_errors();
        test_fe_abort();
        test_line_count();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
